// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic light controller: state encoding,
// lamp bundle ordering and the phase-duration legality check.
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_MAIN_GREEN  = 3'd0,
      ST_MAIN_YELLOW = 3'd1,
      ST_ALL_RED_A   = 3'd2,
      ST_SIDE_GREEN  = 3'd3,
      ST_SIDE_YELLOW = 3'd4,
      ST_ALL_RED_B   = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ,
      ST_FLASH       = 3'd6
`endif
   } state_t;

   // Bit positions inside a per-road lamp bundle.
   localparam int LAMP_R = 0;
   localparam int LAMP_Y = 1;
   localparam int LAMP_G = 2;
   localparam int LAMP_W = 3;

   // A duration of D ticks loads D-1, so D may reach 2^cnt_w but never 0.
   function automatic logic dur_ok(input int unsigned dur, input int unsigned cnt_w);
      longint unsigned limit;
      limit = 64'd1 << cnt_w;
      return (dur >= 1) && (longint'(dur) <= limit);
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Phase down-counter: loads a value on phase entry, decrements on tick and
// parks at zero until the next load.
module phase_timer #(
   parameter int               CNT_W   = 8,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   // Load wins over decrement so a phase change on a tick starts a full phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= RST_VAL;
      end else if (load) begin
         count_reg <= load_val;
      end else if (tick && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero  = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with demand-driven side phase and pedestrian walk.
// Optional night flashing mode is compiled in with TRAFFIC_NIGHT_FLASH_EN.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int MIN_GREEN  = 8,
   parameter int SIDE_GREEN = 5,
   parameter int YELLOW     = 3,
   parameter int ALL_RED    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic side_req,
   input  logic ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic night_mode,
`endif
   output logic main_red,
   output logic main_yellow,
   output logic main_green,
   output logic side_red,
   output logic side_yellow,
   output logic side_green,
   output logic walk,
   output logic ped_wait
);

   localparam logic [CNT_W-1:0] LD_MG = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_SG = CNT_W'(SIDE_GREEN - 1);
   localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] LD_AR = CNT_W'(ALL_RED - 1);

   if (!dur_ok(MIN_GREEN, CNT_W)) begin : g_chk_mg
      $error("MIN_GREEN out of range for CNT_W");
   end
   if (!dur_ok(SIDE_GREEN, CNT_W)) begin : g_chk_sg
      $error("SIDE_GREEN out of range for CNT_W");
   end
   if (!dur_ok(YELLOW, CNT_W)) begin : g_chk_y
      $error("YELLOW out of range for CNT_W");
   end
   if (!dur_ok(ALL_RED, CNT_W)) begin : g_chk_ar
      $error("ALL_RED out of range for CNT_W");
   end

   state_t           state_reg, state_next;
   logic             side_pend_reg, ped_pend_reg, walk_latched_reg;
   logic             load, capture, accept, night_clear;
   logic [CNT_W-1:0] load_val;
   logic             timer_zero;
   logic [CNT_W-1:0] timer_count;
   logic [2:0]       main_lamp, side_lamp;

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_AR)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (load),
      .load_val (load_val),
      .zero     (timer_zero),
      .count    (timer_count)
   );

`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic flash_ph_reg;

   assign night_clear = tick & night_mode;

   always_ff @(posedge clk) begin
      if (reset) begin
         flash_ph_reg <= 1'b0;
      end else if (night_clear) begin
         flash_ph_reg <= (state_reg == ST_FLASH) ? ~flash_ph_reg : 1'b0;
      end
   end
`else
   assign night_clear = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_ALL_RED_B;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      load_val   = LD_AR;
      capture    = 1'b0;
      if (tick) begin
         case (state_reg)
            ST_ALL_RED_B: if (timer_zero) begin
               state_next = ST_MAIN_GREEN;
               load       = 1'b1;
               load_val   = LD_MG;
            end
            // Main green only yields once its minimum has run and someone is waiting.
            ST_MAIN_GREEN: if (timer_zero && (side_pend_reg || ped_pend_reg)) begin
               state_next = ST_MAIN_YELLOW;
               load       = 1'b1;
               load_val   = LD_Y;
            end
            ST_MAIN_YELLOW: if (timer_zero) begin
               state_next = ST_ALL_RED_A;
               load       = 1'b1;
               load_val   = LD_AR;
            end
            ST_ALL_RED_A: if (timer_zero) begin
               state_next = ST_SIDE_GREEN;
               load       = 1'b1;
               load_val   = LD_SG;
               capture    = 1'b1;
            end
            ST_SIDE_GREEN: if (timer_zero) begin
               state_next = ST_SIDE_YELLOW;
               load       = 1'b1;
               load_val   = LD_Y;
            end
            ST_SIDE_YELLOW: if (timer_zero) begin
               state_next = ST_ALL_RED_B;
               load       = 1'b1;
               load_val   = LD_AR;
            end
            default: begin
               state_next = ST_ALL_RED_B;
               load       = 1'b1;
               load_val   = LD_AR;
            end
         endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
         if (night_mode) begin
            state_next = ST_FLASH;
            load       = 1'b0;
            capture    = 1'b0;
         end
`endif
      end
   end

   // Requests are ignored while the side road is already being served.
   assign accept = (state_reg != ST_SIDE_GREEN) && (state_reg != ST_SIDE_YELLOW);

   always_ff @(posedge clk) begin
      if (reset) begin
         side_pend_reg    <= 1'b0;
         ped_pend_reg     <= 1'b0;
         walk_latched_reg <= 1'b0;
      end else if (night_clear) begin
         side_pend_reg    <= 1'b0;
         ped_pend_reg     <= 1'b0;
         walk_latched_reg <= 1'b0;
      end else if (capture) begin
         side_pend_reg    <= 1'b0;
         ped_pend_reg     <= 1'b0;
         walk_latched_reg <= ped_pend_reg;
      end else if (accept) begin
         side_pend_reg    <= side_pend_reg | side_req;
         ped_pend_reg     <= ped_pend_reg | ped_req;
      end
   end

   always_comb begin
      main_lamp         = '0;
      side_lamp         = '0;
      main_lamp[LAMP_R] = 1'b1;
      side_lamp[LAMP_R] = 1'b1;
      case (state_reg)
         ST_MAIN_GREEN: begin
            main_lamp         = '0;
            main_lamp[LAMP_G] = 1'b1;
         end
         ST_MAIN_YELLOW: begin
            main_lamp         = '0;
            main_lamp[LAMP_Y] = 1'b1;
         end
         ST_SIDE_GREEN: begin
            side_lamp         = '0;
            side_lamp[LAMP_G] = 1'b1;
         end
         ST_SIDE_YELLOW: begin
            side_lamp         = '0;
            side_lamp[LAMP_Y] = 1'b1;
         end
`ifdef TRAFFIC_NIGHT_FLASH_EN
         ST_FLASH: begin
            main_lamp         = '0;
            side_lamp         = '0;
            main_lamp[LAMP_Y] = flash_ph_reg;
            side_lamp[LAMP_Y] = flash_ph_reg;
         end
`endif
         default: ;
      endcase
   end

   assign main_red    = main_lamp[LAMP_R];
   assign main_yellow = main_lamp[LAMP_Y];
   assign main_green  = main_lamp[LAMP_G];
   assign side_red    = side_lamp[LAMP_R];
   assign side_yellow = side_lamp[LAMP_Y];
   assign side_green  = side_lamp[LAMP_G];
   assign walk        = (state_reg == ST_SIDE_GREEN) & walk_latched_reg;
   assign ped_wait    = ped_pend_reg;

   a_no_conflict: assert property (@(posedge clk)
      !((main_green | main_yellow) & (side_green | side_yellow)));
   a_timer_zero: assert property (@(posedge clk)
      timer_zero == (timer_count == '0));

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with default durations and a tick every 4 clks.
module tb_traffic_light_ctrl;

   // {main R,Y,G, side R,Y,G, walk, ped_wait}
   localparam logic [7:0] P_AR  = 8'b100_100_0_0;
   localparam logic [7:0] P_ARW = 8'b100_100_0_1;
   localparam logic [7:0] P_MG  = 8'b001_100_0_0;
   localparam logic [7:0] P_MGW = 8'b001_100_0_1;
   localparam logic [7:0] P_MY  = 8'b010_100_0_0;
   localparam logic [7:0] P_MYW = 8'b010_100_0_1;
   localparam logic [7:0] P_SG  = 8'b100_001_0_0;
   localparam logic [7:0] P_SGW = 8'b100_001_1_0;
   localparam logic [7:0] P_SY  = 8'b100_010_0_0;
   localparam logic [7:0] P_FL0 = 8'b000_000_0_0;
   localparam logic [7:0] P_FL1 = 8'b010_010_0_0;

   logic clk = 1'b0;
   logic reset, tick, side_req, ped_req;
   logic main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk, ped_wait;
   logic [7:0] lamps;
   int n_checks = 0;
   int n_fail   = 0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic night_mode = 1'b0;
`endif

   always #5 clk = ~clk;

   traffic_light_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .side_req    (side_req),
      .ped_req     (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
      .night_mode  (night_mode),
`endif
      .main_red    (main_red),
      .main_yellow (main_yellow),
      .main_green  (main_green),
      .side_red    (side_red),
      .side_yellow (side_yellow),
      .side_green  (side_green),
      .walk        (walk),
      .ped_wait    (ped_wait)
   );

   assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk, ped_wait};

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (3) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   // Expect pattern p for n consecutive tick intervals, ending just after the n-th tick.
   task automatic hold(input string tag, input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d]", tag, i), lamps, p);
         ticks(1);
      end
   endtask

   task automatic pulse_side();
      side_req = 1'b1;
      @(negedge clk);
      side_req = 1'b0;
   endtask

   task automatic pulse_ped();
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; tick = 1'b1; side_req = 1'b0; ped_req = 1'b0;
      repeat (4) @(negedge clk);
      tick = 1'b0; reset = 1'b0;
      check("reset", lamps, P_AR);

      // Startup clearance then idle main green.
      hold("ar_start", P_AR, 2);
      hold("mg_idle", P_MG, 30);
      check("mg_idle_end", lamps, P_MG);

      // Demand after minimum already served: leaves on the next tick.
      pulse_side();
      check("mg_pend", lamps, P_MG);
      ticks(1);
      hold("my1", P_MY, 3);
      hold("ara1", P_AR, 2);
      hold("sg1", P_SG, 5);
      hold("sy1", P_SY, 3);
      hold("arb1", P_AR, 2);

      // Side request at tick 2 of main green: green lasts exactly 8 ticks.
      hold("mg2a", P_MG, 2);
      pulse_side();
      hold("mg2b", P_MG, 6);
      hold("my2", P_MY, 3);
      hold("ara2", P_AR, 2);
      hold("sg2", P_SG, 5);
      hold("sy2", P_SY, 3);
      hold("arb2", P_AR, 2);

      // Pedestrian request: ped_wait until side-green entry, then walk for 5 ticks.
      hold("mg3a", P_MG, 1);
      pulse_ped();
      hold("mg3b", P_MGW, 7);
      hold("my3", P_MYW, 3);
      hold("ara3", P_ARW, 2);
      hold("sg3_walk", P_SGW, 5);
      hold("sy3", P_SY, 3);
      hold("arb3", P_AR, 2);

      // Side request held during side green is not latched.
      pulse_side();
      hold("mg4", P_MG, 8);
      hold("my4", P_MY, 3);
      hold("ara4", P_AR, 2);
      side_req = 1'b1;
      hold("sg4_req", P_SG, 5);
      side_req = 1'b0;
      hold("sy4", P_SY, 3);
      hold("arb4", P_AR, 2);
      hold("mg4_hold", P_MG, 12);

      // Reset in the middle of side yellow.
      pulse_side();
      hold("mg5", P_MG, 1);
      hold("my5", P_MY, 3);
      hold("ara5", P_AR, 2);
      hold("sg5", P_SG, 5);
      hold("sy5", P_SY, 1);
      check("sy5_mid", lamps, P_SY);
      reset = 1'b1;
      @(negedge clk);
      check("reset_sy", lamps, P_AR);
      reset = 1'b0;
      hold("arb5", P_AR, 2);
      check("mg5_after_reset", lamps, P_MG);

      // Reset clears a pending pedestrian request.
      pulse_ped();
      check("mg6_pw", lamps, P_MGW);
      reset = 1'b1;
      @(negedge clk);
      check("reset_pw", lamps, P_AR);
      reset = 1'b0;
      hold("arb6", P_AR, 2);
      check("mg6", lamps, P_MG);

`ifdef TRAFFIC_NIGHT_FLASH_EN
      pulse_side();
      hold("mg7", P_MG, 8);
      hold("my7", P_MY, 3);
      hold("ara7", P_AR, 2);
      night_mode = 1'b1;
      check("sg7", lamps, P_SG);
      ticks(1);
      check("flash0", lamps, P_FL0);
      ticks(1);
      check("flash1", lamps, P_FL1);
      ticks(1);
      check("flash2", lamps, P_FL0);
      night_mode = 1'b0;
      ticks(1);
      hold("arb7", P_AR, 2);
      check("mg7_after_flash", lamps, P_MG);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
